// File: rtl/minterm_sweep_checker_pkg.sv
// Shared types and constants for the minterm sweep checker and its bench.
package minterm_sweep_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // F = sum of minterms (0,2,5,7,11,14) for the 4-variable mux stage
    localparam logic [15:0] MINTERMS_CH4P32 = 16'h48A5;

endpackage

// File: rtl/minterm_sweep_checker.sv
// Sweeps every input code through the function stage, captures its truth table
// and compares it against the expected minterm mask.
module minterm_sweep_checker
    import minterm_sweep_checker_pkg::*;
#(
    parameter int               N      = 4,
    parameter int               DWELL  = 4,
    parameter logic [2**N-1:0]  EXPECT = MINTERMS_CH4P32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [N-1:0]      s_out,
    input  logic              y_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [2**N-1:0]   tt_out,
    output logic [N:0]        err_count,
    output logic [N-1:0]      first_err_code,
    output logic              first_err_valid
);

    localparam int              DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
    localparam logic [N-1:0]    CODE_LAST  = '1;

    state_t            state_q, state_d;
    logic [N-1:0]      code_q, code_d;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic [2**N-1:0]   tt_q, tt_d;
    logic [N:0]        err_q, err_d;
    logic [N-1:0]      fec_q, fec_d;
    logic              fev_q, fev_d;
    logic              pass_q, pass_d;
    logic              mismatch;

    assign mismatch = y_in ^ EXPECT[code_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= '0;
            dwell_q <= '0;
            tt_q    <= '0;
            err_q   <= '0;
            fec_q   <= '0;
            fev_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            dwell_q <= dwell_d;
            tt_q    <= tt_d;
            err_q   <= err_d;
            fec_q   <= fec_d;
            fev_q   <= fev_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        dwell_d = dwell_q;
        tt_d    = tt_q;
        err_d   = err_q;
        fec_d   = fec_q;
        fev_d   = fev_q;
        pass_d  = pass_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    code_d  = '0;
                    dwell_d = '0;
                    tt_d    = '0;
                    err_d   = '0;
                    fec_d   = '0;
                    fev_d   = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                // Abort discards any sample that would land on this same edge
                if (abort) begin
                    state_d = IDLE;
                    code_d  = '0;
                    dwell_d = '0;
                    pass_d  = 1'b0;
                end else if (dwell_q == DWELL_LAST) begin
                    tt_d[code_q] = y_in;
                    dwell_d      = '0;
                    if (mismatch) begin
                        err_d = err_q + (N+1)'(1);
                        if (!fev_q) begin
                            fec_d = code_q;
                            fev_d = 1'b1;
                        end
                    end
                    if (code_q == CODE_LAST) begin
                        state_d = DONE;
                        pass_d  = (err_q == '0) && !mismatch;
                    end else begin
                        code_d = code_q + N'(1);
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                code_d  = '0;
                dwell_d = '0;
            end
        endcase
    end

    assign s_out           = code_q;
    assign busy            = (state_q == RUN);
    assign done            = (state_q == DONE);
    assign pass            = pass_q;
    assign tt_out          = tt_q;
    assign err_count       = err_q;
    assign first_err_code  = fec_q;
    assign first_err_valid = fev_q;

endmodule
